// File: rtl/addr_ctr_pkg.sv
// Shared types for the address counter: the operation encoding and the
// priority decoder that maps control strobes onto a single operation.
package addr_ctr_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_DEC,
    OP_JMP,
    OP_CALL,
    OP_RET
  } op_e;

  // ret beats call beats jmp beats counting; exactly one op per cycle.
  function automatic op_e decode_op(
    input logic en,
    input logic ret,
    input logic call,
    input logic jmp,
    input logic dir
  );
    if (!en)       return OP_HOLD;
    else if (ret)  return OP_RET;
    else if (call) return OP_CALL;
    else if (jmp)  return OP_JMP;
    else if (dir)  return OP_INC;
    else           return OP_DEC;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: registered occupancy and flags, top entry readable
// combinationally so a pop can load the counter in the same cycle.
module ret_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int CW    = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MEM_D = 1 << AW;

  logic [WIDTH-1:0] r_mem [MEM_D];
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;

  logic [CW-1:0]    w_count_nxt;
  logic             w_do_push;
  logic             w_do_pop;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;

  assign w_do_push = push && !r_full;
  assign w_do_pop  = pop && !r_empty && !push;
  assign w_wr_idx  = r_count[AW-1:0];
  assign w_rd_idx  = r_count[AW-1:0] - AW'(1);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push)     w_count_nxt = r_count + CW'(1);
    else if (w_do_pop) w_count_nxt = r_count - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // NOTE: storage is not reset; occupancy alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && w_do_push) r_mem[w_wr_idx] <= din;
  end

  assign dout  = r_mem[w_rd_idx];
  assign full  = r_full;
  assign empty = r_empty;

endmodule

// File: rtl/addr_ctr.sv
// Bounded memory-address counter with step, wrap/saturate bounds and a
// call/return LIFO. All outputs are registered on clk.
module addr_ctr
  import addr_ctr_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int STEP        = 1,
  parameter int RST_VAL     = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_loc,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] lo_bound,
  input  logic [WIDTH-1:0] hi_bound,
  input  logic             wrap_mode,
  output logic [WIDTH-1:0] ctr_out,
  output logic             at_bound,
  output logic             stk_empty,
  output logic             stk_full,
  output logic             stk_err
);

  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] r_ctr;
  logic             r_err;
  logic             r_at_bound;

  op_e              w_op;
  logic             w_stk_full;
  logic             w_stk_empty;
  logic [WIDTH-1:0] w_stk_top;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_ret_addr;
  logic [WIDTH:0]   w_inc_sum;
  logic [WIDTH:0]   w_dec_floor;
  logic             w_inc_over;
  logic             w_dec_under;
  logic [WIDTH-1:0] w_ctr_nxt;
  logic             w_err_set;

  assign w_op = decode_op(en, ret, call, jmp, dir);

  assign w_push     = (w_op == OP_CALL) && !w_stk_full;
  assign w_pop      = (w_op == OP_RET) && !w_stk_empty;
  assign w_ret_addr = r_ctr + STEP_X[WIDTH-1:0];

  // One extra bit so overflow past 2^WIDTH and underflow below zero both
  // show up as ordinary out-of-bound comparisons.
  assign w_inc_sum   = {1'b0, r_ctr} + STEP_X;
  assign w_inc_over  = (w_inc_sum > {1'b0, hi_bound}) || (r_ctr > hi_bound);
  assign w_dec_floor = {1'b0, lo_bound} + STEP_X;
  assign w_dec_under = {1'b0, r_ctr} < w_dec_floor;

  always_comb begin
    w_ctr_nxt = r_ctr;
    w_err_set = 1'b0;
    unique case (w_op)
      OP_RET: begin
        if (w_stk_empty) w_err_set = 1'b1;
        else             w_ctr_nxt = w_stk_top;
      end
      OP_CALL: begin
        if (w_stk_full) w_err_set = 1'b1;
        else            w_ctr_nxt = jmp_loc;
      end
      OP_JMP: w_ctr_nxt = jmp_loc;
      OP_INC: begin
        if (w_inc_over) w_ctr_nxt = wrap_mode ? lo_bound : hi_bound;
        else            w_ctr_nxt = w_inc_sum[WIDTH-1:0];
      end
      OP_DEC: begin
        if (w_dec_under) w_ctr_nxt = wrap_mode ? hi_bound : lo_bound;
        else             w_ctr_nxt = r_ctr - STEP_X[WIDTH-1:0];
      end
      default: w_ctr_nxt = r_ctr;
    endcase
  end

  // at_bound is evaluated on the value being loaded so it lines up with ctr_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctr      <= RST_W;
      r_err      <= 1'b0;
      r_at_bound <= (RST_W == lo_bound) || (RST_W == hi_bound);
    end else if (en) begin
      r_ctr      <= w_ctr_nxt;
      r_at_bound <= (w_ctr_nxt == lo_bound) || (w_ctr_nxt == hi_bound);
      if (w_err_set) r_err <= 1'b1;
    end
  end

  ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_ret_addr),
    .dout  (w_stk_top),
    .full  (w_stk_full),
    .empty (w_stk_empty)
  );

  assign ctr_out   = r_ctr;
  assign at_bound  = r_at_bound;
  assign stk_empty = w_stk_empty;
  assign stk_full  = w_stk_full;
  assign stk_err   = r_err;

endmodule

// File: tb/tb_addr_ctr.sv
// Self-checking bench: two counters (STEP=1 and STEP=4) share stimulus and
// are compared every cycle against an arithmetic reference model.
module tb_addr_ctr;

  localparam int W     = 10;
  localparam int DEPTH = 4;
  localparam int NDUT  = 2;
  localparam int SPAN  = 1 << W;

  logic         clk = 1'b0;
  logic         rst, en, dir, jmp, call, ret, wrap_mode;
  logic [W-1:0] jmp_loc, lo_bound, hi_bound;

  logic [W-1:0] ctr0, ctr1;
  logic         atb0, atb1, emp0, emp1, full0, full1, err0, err1;

  int n_vec = 0;
  int n_err = 0;

  int m_ctr [NDUT];
  int m_cnt [NDUT];
  int m_stk [NDUT][DEPTH];
  bit m_err [NDUT];
  bit m_atb [NDUT];

  always #5 clk = ~clk;

  addr_ctr #(.WIDTH(W), .STEP(1), .RST_VAL(0), .STACK_DEPTH(DEPTH)) u_dut_s1 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .jmp(jmp), .jmp_loc(jmp_loc),
    .call(call), .ret(ret), .lo_bound(lo_bound), .hi_bound(hi_bound),
    .wrap_mode(wrap_mode), .ctr_out(ctr0), .at_bound(atb0),
    .stk_empty(emp0), .stk_full(full0), .stk_err(err0)
  );

  addr_ctr #(.WIDTH(W), .STEP(4), .RST_VAL(12), .STACK_DEPTH(DEPTH)) u_dut_s4 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .jmp(jmp), .jmp_loc(jmp_loc),
    .call(call), .ret(ret), .lo_bound(lo_bound), .hi_bound(hi_bound),
    .wrap_mode(wrap_mode), .ctr_out(ctr1), .at_bound(atb1),
    .stk_empty(emp1), .stk_full(full1), .stk_err(err1)
  );

  function automatic int step_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic int rst_val_of(input int k);
    return (k == 0) ? 0 : 12;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: plain integer arithmetic and an array stack.
  task automatic model_update(input int k);
    int s, lo, hi;
    s  = step_of(k);
    lo = int'(lo_bound);
    hi = int'(hi_bound);
    if (rst) begin
      m_ctr[k] = rst_val_of(k);
      m_cnt[k] = 0;
      m_err[k] = 1'b0;
      m_atb[k] = (m_ctr[k] == lo) || (m_ctr[k] == hi);
    end else if (en) begin
      if (ret) begin
        if (m_cnt[k] > 0) begin
          m_cnt[k]--;
          m_ctr[k] = m_stk[k][m_cnt[k]];
        end else m_err[k] = 1'b1;
      end else if (call) begin
        if (m_cnt[k] < DEPTH) begin
          m_stk[k][m_cnt[k]] = (m_ctr[k] + s) % SPAN;
          m_cnt[k]++;
          m_ctr[k] = int'(jmp_loc);
        end else m_err[k] = 1'b1;
      end else if (jmp) begin
        m_ctr[k] = int'(jmp_loc);
      end else if (dir) begin
        if (m_ctr[k] + s > hi || m_ctr[k] > hi) m_ctr[k] = wrap_mode ? lo : hi;
        else m_ctr[k] = m_ctr[k] + s;
      end else begin
        if (m_ctr[k] < lo + s) m_ctr[k] = wrap_mode ? hi : lo;
        else m_ctr[k] = m_ctr[k] - s;
      end
      m_atb[k] = (m_ctr[k] == lo) || (m_ctr[k] == hi);
    end
  endtask

  task automatic check_one(input int k, input logic [W-1:0] c, input logic a,
                           input logic e, input logic f, input logic x);
    check($sformatf("d%0d ctr_out", k), int'(c), m_ctr[k]);
    check($sformatf("d%0d at_bound", k), int'(a), int'(m_atb[k]));
    check($sformatf("d%0d stk_empty", k), int'(e), int'(m_cnt[k] == 0));
    check($sformatf("d%0d stk_full", k), int'(f), int'(m_cnt[k] == DEPTH));
    check($sformatf("d%0d stk_err", k), int'(x), int'(m_err[k]));
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) model_update(k);
    #1;
    check_one(0, ctr0, atb0, emp0, full0, err0);
    check_one(1, ctr1, atb1, emp1, full1, err1);
  endtask

  task automatic drive(input logic r, input logic e, input logic d, input logic j,
                       input logic c, input logic rt, input int jl);
    rst = r; en = e; dir = d; jmp = j; call = c; ret = rt;
    jmp_loc = W'(jl);
    tick();
  endtask

  initial begin
    int lo_i, hi_i;
    rst = 1'b0; en = 1'b0; dir = 1'b1; jmp = 1'b0; call = 1'b0; ret = 1'b0;
    jmp_loc = '0; lo_bound = '0; hi_bound = W'(SPAN - 1); wrap_mode = 1'b1;

    // Reset then count up from zero.
    drive(1, 0, 1, 0, 0, 0, 0);
    check("reset ctr", int'(ctr0), 0);
    check("reset empty", int'(emp0), 1);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1, 1, 0, 0, 0, 0);
      check("count up", int'(ctr0), i);
    end

    // Wrap versus saturate at both bounds.
    lo_bound = W'(8); hi_bound = W'(20);
    wrap_mode = 1'b1; drive(0, 1, 1, 1, 0, 0, 20); drive(0, 1, 1, 0, 0, 0, 0);
    check("inc wrap", int'(ctr1), 8);
    check("inc wrap atb", int'(atb1), 1);
    wrap_mode = 1'b0; drive(0, 1, 1, 1, 0, 0, 20); drive(0, 1, 1, 0, 0, 0, 0);
    check("inc sat", int'(ctr1), 20);
    wrap_mode = 1'b1; drive(0, 1, 0, 1, 0, 0, 8); drive(0, 1, 0, 0, 0, 0, 0);
    check("dec wrap", int'(ctr1), 20);
    wrap_mode = 1'b0; drive(0, 1, 0, 1, 0, 0, 8); drive(0, 1, 0, 0, 0, 0, 0);
    check("dec sat", int'(ctr1), 8);
    check("dec sat atb", int'(atb1), 1);

    // Call, count, return.
    lo_bound = '0; hi_bound = W'(SPAN - 1); wrap_mode = 1'b1;
    drive(0, 1, 1, 1, 0, 0, 5);
    drive(0, 1, 1, 0, 1, 0, 100);
    check("call target", int'(ctr0), 100);
    check("call nonempty", int'(emp0), 0);
    drive(0, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0);
    check("count after call", int'(ctr0), 102);
    drive(0, 1, 1, 0, 0, 1, 0);
    check("return addr", int'(ctr0), 6);
    check("return empty", int'(emp0), 1);

    // Overflow on the fifth call.
    for (int i = 0; i < 5; i++) drive(0, 1, 1, 0, 1, 0, 50 + 10 * i);
    check("overflow ctr", int'(ctr0), 80);
    check("overflow full", int'(full0), 1);
    check("overflow err", int'(err0), 1);
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 0, 0, 0, 0);
    check("err sticky", int'(err0), 1);

    // Priority: ret wins over call and jmp; en=0 freezes everything.
    drive(1, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 1, 0, 0, 32);
    drive(0, 1, 1, 0, 1, 0, 200);
    drive(0, 1, 1, 1, 1, 1, 500);
    check("prio ret", int'(ctr0), 33);
    check("prio no push", int'(emp0), 1);
    drive(0, 0, 1, 1, 1, 1, 700);
    check("en low hold", int'(ctr0), 33);

    // Underflow, then reset during a call.
    drive(0, 1, 1, 0, 0, 1, 0);
    check("underflow ctr", int'(ctr0), 33);
    check("underflow err", int'(err0), 1);
    drive(1, 1, 1, 0, 1, 0, 300);
    check("rst ctr s1", int'(ctr0), 0);
    check("rst ctr s4", int'(ctr1), 12);
    check("rst err", int'(err0), 0);
    check("rst empty", int'(emp1), 1);

    // Randomised traffic with moving bounds.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) begin
        lo_i = int'($urandom_range(SPAN - 1));
        hi_i = ($urandom_range(1) == 0) ? lo_i + int'($urandom_range(40)) : SPAN - 1;
        if (hi_i > SPAN - 1) hi_i = SPAN - 1;
        hi_i = int'($urandom_range(hi_i, lo_i));
        lo_bound = W'(lo_i);
        hi_bound = W'(hi_i);
      end
      wrap_mode = 1'($urandom_range(1));
      drive(($urandom_range(99) == 0), ($urandom_range(9) != 0), 1'($urandom_range(1)),
            ($urandom_range(9) == 0), ($urandom_range(6) == 0), ($urandom_range(6) == 0),
            ($urandom_range(3) == 0) ? int'(lo_bound) : int'($urandom_range(SPAN - 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
